// File: rtl/punc_control.sv
// Instruction-sequencing control unit for a 16-bit LC-3 style datapath.
// A six-state FSM drives all datapath selects and strobes combinationally from state and ir.
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    output logic [1:0]  MUX_input,
    output logic [1:0]  PCMUX,
    output logic        pcld,
    output logic        pcclr,
    output logic [1:0]  MUX,
    output logic        MUX_w_addr,
    output logic        mem_en,
    output logic        irld,
    output logic        reg_w_en,
    output logic        cond_chk,
    output logic        reg_chk1,
    output logic        reg_chk2,
    output logic        cond_en,
    output logic [2:0]  reg_w_addr,
    output logic [2:0]  regIn1,
    output logic [2:0]  regIn2,
    output logic [15:0] regIn3,
    output logic [3:0]  ALU_Cur,
    output logic        halted
);

    typedef enum logic [2:0] {INIT, FETCH, DECODE, EXEC, EXEC2, HALT} state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_PASS = 4'b0100;
    localparam logic [3:0] ALU_NOT  = 4'b1000;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] opcode;

    assign opcode = ir[15:12];

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        MUX_input  = 2'b00;
        PCMUX      = 2'b11;
        pcclr      = 1'b0;
        MUX        = 2'b00;
        MUX_w_addr = 1'b0;
        mem_en     = 1'b0;
        irld       = 1'b0;
        reg_w_en   = 1'b0;
        cond_chk   = 1'b0;
        reg_chk1   = 1'b0;
        reg_chk2   = 1'b0;
        cond_en    = 1'b0;
        reg_w_addr = 3'd0;
        regIn1     = 3'd0;
        regIn2     = 3'd0;
        regIn3     = 16'h0000;
        ALU_Cur    = ALU_ADD;
        halted     = 1'b0;

        case (state)
            INIT: begin
                pcclr     = 1'b1;
                state_nxt = FETCH;
            end

            FETCH: begin
                MUX_input = 2'b00;
                irld      = 1'b1;
                PCMUX     = 2'b01;
                state_nxt = DECODE;
            end

            DECODE: begin
                // JSR (ir[11]=1) carries an 11-bit offset; everything else a 9-bit one
                if (opcode == OP_JSR && ir[11]) begin
                    regIn3 = sext11(ir[10:0]);
                end else begin
                    regIn3 = sext9(ir[8:0]);
                end
                if (opcode == OP_LDR || opcode == OP_STR) begin
                    reg_chk1 = 1'b1;
                    regIn1   = ir[8:6];
                    regIn3   = sext6(ir[5:0]);
                end
                if (opcode == OP_JMP || (opcode == OP_JSR && !ir[11])) begin
                    reg_chk1 = 1'b1;
                    regIn1   = ir[8:6];
                    ALU_Cur  = ALU_PASS;
                end
                state_nxt = EXEC;
            end

            EXEC: begin
                state_nxt = FETCH;
                case (opcode)
                    OP_ADD, OP_AND, OP_NOT: begin
                        regIn1     = ir[8:6];
                        reg_chk1   = 1'b1;
                        reg_chk2   = ~ir[5];
                        regIn2     = ir[2:0];
                        regIn3     = sext5(ir[4:0]);
                        ALU_Cur    = (opcode == OP_ADD) ? ALU_ADD :
                                     (opcode == OP_AND) ? ALU_AND : ALU_NOT;
                        reg_w_en   = 1'b1;
                        reg_w_addr = ir[11:9];
                        cond_chk   = 1'b1;
                        cond_en    = 1'b1;
                    end
                    OP_LEA: begin
                        regIn3     = sext9(ir[8:0]);
                        reg_w_en   = 1'b1;
                        reg_w_addr = ir[11:9];
                    end
                    OP_LD, OP_LDR: begin
                        MUX_input  = 2'b10;
                        MUX        = 2'b01;
                        reg_w_en   = 1'b1;
                        reg_w_addr = ir[11:9];
                        cond_en    = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        mem_en   = 1'b1;
                        reg_chk2 = 1'b1;
                        regIn2   = ir[11:9];
                    end
                    OP_LDI, OP_STI: begin
                        MUX_input = 2'b10;
                        state_nxt = EXEC2;
                    end
                    OP_BR: begin
                        if ((ir[11] & N) | (ir[10] & Z) | (ir[9] & P)) begin
                            PCMUX = 2'b00;
                        end
                    end
                    OP_JMP: begin
                        PCMUX = 2'b00;
                    end
                    OP_JSR: begin
                        // R7 captures the pre-jump pc on the same edge the pc is redirected
                        reg_w_en   = 1'b1;
                        reg_w_addr = 3'd7;
                        MUX        = 2'b10;
                        PCMUX      = 2'b00;
                    end
                    OP_HALT: begin
                        state_nxt = HALT;
                    end
                    default: begin
                    end
                endcase
            end

            EXEC2: begin
                state_nxt = FETCH;
                if (opcode == OP_LDI) begin
                    MUX_input  = 2'b11;
                    MUX        = 2'b01;
                    reg_w_en   = 1'b1;
                    reg_w_addr = ir[11:9];
                    cond_en    = 1'b1;
                end else if (opcode == OP_STI) begin
                    mem_en     = 1'b1;
                    MUX_w_addr = 1'b1;
                    reg_chk2   = 1'b1;
                    regIn2     = ir[11:9];
                end
            end

            HALT: begin
                halted    = 1'b1;
                state_nxt = HALT;
            end

            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign pcld = (PCMUX != 2'b11);

endmodule
